// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encoding and defaults.
package uart_loader_pkg;

  // Frame parsing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4
  } state_t;

  // Default frame start marker
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Payload byte count width (two length bytes)
  localparam int COUNT_WIDTH = 16;

endpackage

// File: rtl/uart_loader_timer.sv
// Inter-byte watchdog: counts enabled clocks since the last restart and
// raises a one-cycle expiry pulse once TIMEOUT_CYCLES clocks have elapsed.
module uart_loader_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_expire
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_count;

  // Count idle clocks; any accepted byte or a disabled timer clears it.
  // The count saturates at LAST so it never wraps back to a fresh interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_restart || !i_enable) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + TW'(1);
    end
  end

  // A byte arriving on the expiry cycle suppresses the pulse
  assign o_expire = i_enable && !i_restart && (r_count == LAST);

endmodule

// File: rtl/uart_loader.sv
// UART program loader: frames SYNC/LEN_HI/LEN_LO/payload/CHK packets,
// writes the payload to memory sequentially and releases the CPU hold only
// after a frame with a matching checksum.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 16,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_rx_data,
  input  logic                  in_rx_data_valid,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  output logic [7:0]            out_mem_data,
  output logic                  out_mem_we,
  output logic                  out_cpu_hold,
  output logic                  out_busy,
  output logic                  out_load_done,
  output logic                  out_error
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [COUNT_WIDTH-1:0]  r_count,    w_count_next;
  logic [ADDR_WIDTH-1:0]   r_addr,     w_addr_next;
  logic [7:0]              r_sum,      w_sum_next;
  logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr_next;
  logic [7:0]              r_mem_data, w_mem_data_next;
  logic                    r_mem_we,   w_mem_we_next;
  logic                    r_cpu_hold, w_cpu_hold_next;
  logic                    r_load_done, w_load_done_next;
  logic                    r_error,    w_error_next;
  logic                    w_expire;
  logic [COUNT_WIDTH-1:0]  w_len;

  // Full length as soon as the low byte arrives
  assign w_len = {r_count[COUNT_WIDTH-1:8], in_rx_data};

  uart_loader_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (in_rx_data_valid),
    .i_enable  (r_state != ST_IDLE),
    .o_expire  (w_expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: bytes advance the frame, expiry aborts it
  always_comb begin
    w_state_next = r_state;
    if (in_rx_data_valid) begin
      case (r_state)
        ST_IDLE:    if (in_rx_data == SYNC_BYTE) w_state_next = ST_LEN_HI;
        ST_LEN_HI:  w_state_next = ST_LEN_LO;
        ST_LEN_LO:  w_state_next = (w_len == '0) ? ST_CHECK : ST_PAYLOAD;
        ST_PAYLOAD: if (r_count == COUNT_WIDTH'(1)) w_state_next = ST_CHECK;
        ST_CHECK:   w_state_next = ST_IDLE;
        default:    w_state_next = ST_IDLE;
      endcase
    end else if (w_expire) begin
      w_state_next = ST_IDLE;
    end
  end

  // Output/datapath logic: next values for count, address, sum and outputs
  always_comb begin
    w_count_next     = r_count;
    w_addr_next      = r_addr;
    w_sum_next       = r_sum;
    w_mem_addr_next  = r_mem_addr;
    w_mem_data_next  = r_mem_data;
    w_mem_we_next    = 1'b0;
    w_cpu_hold_next  = r_cpu_hold;
    w_load_done_next = 1'b0;
    w_error_next     = r_error;
    if (in_rx_data_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (in_rx_data == SYNC_BYTE) begin
            w_cpu_hold_next = 1'b1;
            w_error_next    = 1'b0;
            w_addr_next     = '0;
            w_sum_next      = '0;
          end
        end
        ST_LEN_HI: w_count_next = {in_rx_data, 8'h00};
        ST_LEN_LO: w_count_next = w_len;
        ST_PAYLOAD: begin
          w_mem_addr_next = r_addr;
          w_mem_data_next = in_rx_data;
          w_mem_we_next   = 1'b1;
          w_sum_next      = r_sum + in_rx_data;
          w_addr_next     = r_addr + ADDR_WIDTH'(1);
          w_count_next    = r_count - COUNT_WIDTH'(1);
        end
        ST_CHECK: begin
          if (in_rx_data == r_sum) begin
            w_cpu_hold_next  = 1'b0;
            w_load_done_next = 1'b1;
          end else begin
            w_error_next = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (w_expire) begin
      w_error_next = 1'b1;
    end
  end

  // Datapath and output registers; reset holds the CPU until the first load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_addr      <= '0;
      r_sum       <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_we    <= 1'b0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_addr      <= w_addr_next;
      r_sum       <= w_sum_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_data  <= w_mem_data_next;
      r_mem_we    <= w_mem_we_next;
      r_cpu_hold  <= w_cpu_hold_next;
      r_load_done <= w_load_done_next;
      r_error     <= w_error_next;
    end
  end

  assign out_mem_addr  = r_mem_addr;
  assign out_mem_data  = r_mem_data;
  assign out_mem_we    = r_mem_we;
  assign out_cpu_hold  = r_cpu_hold;
  assign out_busy      = (r_state != ST_IDLE);
  assign out_load_done = r_load_done;
  assign out_error     = r_error;

endmodule
